// File: rtl/sdffr_dis_led_bank_if.sv
// Signal bundle for the scan/hold register bank with LED outputs.
// The master drives controls and data; the slave (the bank) returns register and LED state.
interface sdffr_dis_led_bank_if #(
  parameter int WIDTH = 8
);
  logic             dis_i;
  logic             scan_en_i;
  logic             scan_d_i;
  logic [WIDTH-1:0] d_i;
  logic             led_mode_i;
  logic [WIDTH-1:0] q_o;
  logic             scan_q_o;
  logic [WIDTH-1:0] led_o;

  modport master (
    output dis_i,
    output scan_en_i,
    output scan_d_i,
    output d_i,
    output led_mode_i,
    input  q_o,
    input  scan_q_o,
    input  led_o
  );

  modport slave (
    input  dis_i,
    input  scan_en_i,
    input  scan_d_i,
    input  d_i,
    input  led_mode_i,
    output q_o,
    output scan_q_o,
    output led_o
  );
endinterface

// File: rtl/sdffr_dis_led_bank.sv
// Scannable register bank with hold enable and per-bit LED drive,
// showing either the register level or a stretched activity pulse per bit.
module sdffr_dis_led_bank #(
  parameter int WIDTH   = 8,
  parameter int STRETCH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  sdffr_dis_led_bank_if.slave  bank
);
  localparam int CNT_W = $clog2(STRETCH + 1);
  localparam logic [CNT_W-1:0] STRETCH_C = CNT_W'(STRETCH);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] shift_val;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] active;

  generate
    if (WIDTH == 1) begin : g_shift_one
      assign shift_val = bank.scan_d_i;
    end else begin : g_shift_many
      assign shift_val = {data_q[WIDTH-2:0], bank.scan_d_i};
    end
  endgenerate

  // Scan has priority over hold; reset is applied in the register process.
  always_comb begin
    data_d = data_q;
    if (bank.scan_en_i) begin
      data_d = shift_val;
    end else if (!bank.dis_i) begin
      data_d = bank.d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  // A hold leaves data_d equal to data_q, so it can never look like a toggle.
  assign toggle = data_d ^ data_q;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (toggle[gi]) begin
          cnt_d = STRETCH_C;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign active[gi] = (cnt_q != '0);
    end
  endgenerate

  assign bank.q_o      = data_q;
  assign bank.scan_q_o = data_q[WIDTH-1];
  assign bank.led_o    = bank.led_mode_i ? active : data_q;
endmodule

// File: tb/tb_sdffr_dis_led_bank.sv
// Directed bench for sdffr_dis_led_bank (WIDTH=8, STRETCH=4): vector table
// plus hand-written scan, retrigger, mode-switch and reset-precedence sequences.
module tb_sdffr_dis_led_bank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  sdffr_dis_led_bank_if #(.WIDTH(8)) bus ();

  sdffr_dis_led_bank #(.WIDTH(8), .STRETCH(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bank  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       scan_en;
    logic       scan_d;
    logic       dis;
    logic       led_mode;
    logic [7:0] d;
    logic [7:0] exp_q;
    logic       exp_sq;
    logic [7:0] exp_led;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("check %-16s act=%02h exp=%02h ok", name, act, exp);
    end else begin
      $display("FAIL %-16s act=%02h exp=%02h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic se, input logic sd, input logic ds,
                       input logic [7:0] d, input logic lm);
    rst           = r;
    bus.scan_en_i = se;
    bus.scan_d_i  = sd;
    bus.dis_i     = ds;
    bus.d_i       = d;
    bus.led_mode_i = lm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] pattern;
    logic [7:0] model;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    //               name           rst se sd ds lm d      q      sq    led
    vecs[0]  = '{"rst_init",       1, 1, 0, 0, 1, 8'hFF, 8'h00, 1'b0, 8'h00};
    vecs[1]  = '{"load_a5",        0, 0, 0, 0, 0, 8'hA5, 8'hA5, 1'b1, 8'hA5};
    vecs[2]  = '{"hold_3c",        0, 0, 0, 1, 0, 8'h3C, 8'hA5, 1'b1, 8'hA5};
    vecs[3]  = '{"hold_act_c2",    0, 0, 0, 1, 1, 8'h3C, 8'hA5, 1'b1, 8'hA5};
    vecs[4]  = '{"hold_act_c1",    0, 0, 0, 1, 1, 8'h00, 8'hA5, 1'b1, 8'hA5};
    vecs[5]  = '{"hold_act_c0",    0, 0, 0, 1, 1, 8'h00, 8'hA5, 1'b1, 8'h00};
    vecs[6]  = '{"rst_again",      1, 0, 0, 0, 1, 8'h77, 8'h00, 1'b0, 8'h00};
    vecs[7]  = '{"stretch_load",   0, 0, 0, 0, 1, 8'h01, 8'h01, 1'b0, 8'h01};
    vecs[8]  = '{"stretch_h1",     0, 0, 0, 1, 1, 8'hFF, 8'h01, 1'b0, 8'h01};
    vecs[9]  = '{"stretch_h2",     0, 0, 0, 1, 1, 8'hFF, 8'h01, 1'b0, 8'h01};
    vecs[10] = '{"stretch_h3",     0, 0, 0, 1, 1, 8'hFF, 8'h01, 1'b0, 8'h01};
    vecs[11] = '{"stretch_dark",   0, 0, 0, 1, 1, 8'hFF, 8'h01, 1'b0, 8'h00};
    vecs[12] = '{"level_view",     0, 0, 0, 1, 0, 8'hFF, 8'h01, 1'b0, 8'h01};

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rst, vecs[i].scan_en, vecs[i].scan_d, vecs[i].dis, vecs[i].d, vecs[i].led_mode);
      tick();
      check({vecs[i].name, "_q"},   bus.q_o, vecs[i].exp_q);
      check({vecs[i].name, "_sq"},  {7'b0, bus.scan_q_o}, {7'b0, vecs[i].exp_sq});
      check({vecs[i].name, "_led"}, bus.led_o, vecs[i].exp_led);
    end

    // Scan chain: shift in 1,0,1,1,0,0,0,1 with hold asserted, then shift out.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    pattern = 8'hB1;
    model   = 8'h00;
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, pattern[7-k], 1'b1, 8'hFF, 1'b0);
      tick();
      model = {model[6:0], pattern[7-k]};
      check($sformatf("scan_in%0d", k), bus.q_o, model);
    end
    check("scan_full", bus.q_o, 8'hB1);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0);
      check($sformatf("scan_out%0d", k), {7'b0, bus.scan_q_o}, {7'b0, pattern[7-k]});
      tick();
    end
    check("scan_empty", bus.q_o, 8'h00);

    // Retrigger: toggles at edges t and t+2, dark from t+6.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1);
    tick();
    check("retrig_t0", bus.led_o, 8'h01);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
    tick();
    check("retrig_t1", bus.led_o, 8'h01);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    check("retrig_t2", bus.led_o, 8'h01);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1);
    for (int k = 3; k <= 5; k++) begin
      tick();
      check($sformatf("retrig_t%0d", k), bus.led_o, 8'h01);
    end
    tick();
    check("retrig_t6", bus.led_o, 8'h00);
    tick();
    check("retrig_t7", bus.led_o, 8'h00);

    // Toggle on the edge where the counter sits at 1: no dark cycle.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
    tick();
    tick();
    tick();
    check("edge1_lit", bus.led_o, 8'h01);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    check("edge1_reload", bus.led_o, 8'h01);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1);
    tick();
    tick();
    tick();
    check("edge1_last", bus.led_o, 8'h01);
    tick();
    check("edge1_dark", bus.led_o, 8'h00);

    // Mode switch takes effect without a clock edge.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'hF0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
    for (int k = 0; k < 4; k++) tick();
    check("mode_act", bus.led_o, 8'h00);
    bus.led_mode_i = 1'b0;
    #1;
    check("mode_level", bus.led_o, 8'hF0);
    bus.led_mode_i = 1'b1;
    #1;
    check("mode_back", bus.led_o, 8'h00);

    // Reset mid-stretch overrides scan and data; next edge is normal.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h0F, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
    tick();
    check("pre_rst_led", bus.led_o, 8'hFF);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1);
    tick();
    check("rstp_q", bus.q_o, 8'h00);
    check("rstp_led_act", bus.led_o, 8'h00);
    bus.led_mode_i = 1'b0;
    #1;
    check("rstp_led_lvl", bus.led_o, 8'h00);
    check("rstp_sq", {7'b0, bus.scan_q_o}, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1);
    tick();
    check("post_rst_q", bus.q_o, 8'h5A);
    check("post_rst_led", bus.led_o, 8'h5A);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
